menu_overlay_render: RTL and testbench
======================================

# menu_overlay_render

Pixel renderer for the on-screen menu. Sits downstream of the 2 KB dual-port menu RAM and drives its read port B. Per scanline it walks the 32×28 character buffer, fetches 8×8 glyph rows from the font area, and serializes them into a 1-bit foreground stream that the video mixer overlays on the SMS picture. Menu RAM map: 0x000–0x3FF text buffer (32 cols × 32 rows, byte = code), 0x400–0x7FF font (128 glyphs × 8 bytes).

## Interface
- No parameters.
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- enable  in  1  menu shown; 0 forces outputs low, fetches continue
- pix_ce  in  1  pixel strobe, one clk wide, at least 4 clk apart
- line_start  in  1  one-clk pulse ≥4 clk before first pix_ce of a line; y valid for that line
- x  in  8  pixel column of current pix_ce (0–255)
- y  in  8  line being drawn (0–255)
- active  in  1  qualifies pix_ce as a visible pixel
- ram_adb  out  11  menu RAM port B address
- ram_ceb  out  1  port B clock enable (read only; wreb tied 0 outside block)
- ram_doutb  in  8  port B data, valid 1 clk after ram_ceb with address
- pix_fg  out  1  overlay pixel is foreground
- pix_in  out  1  pixel lies inside menu window (y < 224) with enable=1

## Operation
- Fetch FSM: IDLE → CHAR → FONT → LATCH → IDLE.
  - CHAR: ram_adb = {1'b0, y[7:3], col[4:0]}, ram_ceb=1.
  - FONT: capture code = ram_doutb; ram_adb = {1'b1, code[6:0], y[2:0]}, ram_ceb=1.
  - LATCH: next_byte = ram_doutb XOR {8{code[7]}} (bit7 of code = inverse video); next_valid=1.
- Triggers: line_start → fetch col 0. pix_ce && active && x[2:0]==0 → load shift register from next_byte, then fetch col = x[7:3]+1 (mod 32; col 0 fetch at x=248 is harmless, overwritten by next line_start).
- Trigger arriving while FSM not IDLE: abort current fetch, restart at CHAR with new col (line_start always wins).
- Pixel output: on each pix_ce && active, pix_fg = shift[0] (bit0 = leftmost pixel), shift >>= 1. On tile-start pix_ce the loaded byte's bit0 is emitted in the same update.
- If next_valid=0 at tile start, load 0x00 (blank tile); next_valid cleared on every load.
- pix_in = enable && active && y < 224; pix_fg forced 0 when pix_in=0. Rows 28–31 of text buffer (0x380–0x3FF) never displayed.
- ram_ceb=0 and ram_adb holds last value in IDLE/LATCH.

## Timing
- Fetch latency: 3 clk from trigger to next_byte valid; hence 4-clk min pix_ce spacing.
- pix_fg/pix_in registered; update on the clk edge where pix_ce=1, stable until next pix_ce. Pixel latency: 1 clk from pix_ce.
- pix_ce with active=0: pix_in=0, pix_fg=0, no shift, no fetch.
- Reset (async, any state, including mid-fetch): FSM=IDLE, ram_adb=0, ram_ceb=0, shift=0, next_byte=0, next_valid=0, code=0, pix_fg=0, pix_in=0. First line after reset needs line_start; without it, column 0 renders blank.
- line_start and pix_ce in the same cycle: pix_ce shift/output processed, fetch restarts at col 0.

## Test plan
- Char 'A' (0x41) at text[0]; line_start y=0, pix_ce x=0..7 active → ram_adb 0x000 then 0x608; pix_fg sequence for row byte 0x0C = 0,0,1,1,0,0,0,0.
- Inverse: text[33]=0xC1, y=9 (row 1, glyph row 1 = 0x1E), x=8..15 → adb 0x021 then 0x609; pix_fg = 1,0,0,0,0,1,1,1.
- Column wrap: text[31]='!' (0x21), y=0 → fetch at x=240 uses adb 0x01F, 0x508; x=248..255 emit 0x18 → 0,0,0,1,1,0,0,0; fetch at x=248 addresses col 0.
- Window: y=224 with nonzero text → pix_in=0, pix_fg=0 all pixels; enable=0 at y=10 → both 0.
- Abort: line_start during FONT state of previous fetch → FSM returns to CHAR with adb {0,y[7:3],0}; col 0 renders correct glyph.
- Reset asserted in FONT state → all outputs 0 same cycle; after release, pix_ce before line_start renders col 0 blank.

Source files
------------

// File: rtl/menu_overlay_render_if.sv
// Signal bundle between the menu overlay renderer, the video timing/mixer side
// and read port B of the menu RAM.
interface menu_overlay_render_if;
  logic        enable;
  logic        pix_ce;
  logic        line_start;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        active;
  logic [10:0] ram_adb;
  logic        ram_ceb;
  logic [7:0]  ram_doutb;
  logic        pix_fg;
  logic        pix_in;

  modport slave (
    input  enable, pix_ce, line_start, x, y, active, ram_doutb,
    output ram_adb, ram_ceb, pix_fg, pix_in
  );

  modport master (
    output enable, pix_ce, line_start, x, y, active, ram_doutb,
    input  ram_adb, ram_ceb, pix_fg, pix_in
  );
endinterface

// File: rtl/menu_overlay_render.sv
// Menu overlay renderer: fetches one character code plus one glyph row per tile
// from menu RAM port B and shifts it out LSB-first as a 1-bit foreground stream.
module menu_overlay_render (
  input logic                  clk,
  input logic                  reset,
  menu_overlay_render_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CHAR, FONT, LATCH} state_e;

  state_e      state_q, state_d;
  logic [4:0]  col_q, col_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  next_byte_q, next_byte_d;
  logic        next_valid_q, next_valid_d;
  logic [7:0]  shift_q, shift_d;
  logic        pix_fg_q, pix_fg_d;
  logic        pix_in_q, pix_in_d;
  logic [10:0] adb_q;

  logic        pix_act, tile_start, trigger, in_win;
  logic [4:0]  trig_col;
  logic [7:0]  shift_v;
  logic [10:0] adb;
  logic        ceb;

  assign pix_act    = bus.pix_ce & bus.active;
  assign tile_start = pix_act & (bus.x[2:0] == 3'd0);
  assign trigger    = bus.line_start | tile_start;
  // Column 31's successor wraps to 0; the next line_start overwrites that fetch.
  assign trig_col   = bus.line_start ? 5'd0 : bus.x[7:3] + 5'd1;
  assign in_win     = bus.enable & (bus.y < 8'd224);

  always_comb begin
    // NOTE: every variable gets its hold value first so no latch is inferred.
    state_d      = state_q;
    col_d        = col_q;
    code_d       = code_q;
    next_byte_d  = next_byte_q;
    next_valid_d = next_valid_q;
    shift_d      = shift_q;
    pix_fg_d     = pix_fg_q;
    pix_in_d     = pix_in_q;
    adb          = adb_q;
    ceb          = 1'b0;
    shift_v      = shift_q;

    case (state_q)
      CHAR: begin
        adb     = {1'b0, bus.y[7:3], col_q};
        ceb     = 1'b1;
        state_d = FONT;
      end
      FONT: begin
        adb     = {1'b1, bus.ram_doutb[6:0], bus.y[2:0]};
        ceb     = 1'b1;
        code_d  = bus.ram_doutb;
        state_d = LATCH;
      end
      LATCH: begin
        next_byte_d  = bus.ram_doutb ^ {8{code_q[7]}};
        next_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: ;
    endcase

    // A new request abandons whatever fetch is in flight.
    if (trigger) begin
      state_d      = CHAR;
      col_d        = trig_col;
      code_d       = code_q;
      next_byte_d  = next_byte_q;
      next_valid_d = next_valid_q;
    end

    if (bus.pix_ce) begin
      if (bus.active) begin
        if (tile_start) begin
          shift_v      = next_valid_q ? next_byte_q : 8'h00;
          next_valid_d = 1'b0;
        end
        pix_in_d = in_win;
        pix_fg_d = in_win & shift_v[0];
        shift_d  = {1'b0, shift_v[7:1]};
      end else begin
        pix_in_d = 1'b0;
        pix_fg_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      code_q       <= '0;
      next_byte_q  <= '0;
      next_valid_q <= 1'b0;
      shift_q      <= '0;
      pix_fg_q     <= 1'b0;
      pix_in_q     <= 1'b0;
      adb_q        <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      code_q       <= code_d;
      next_byte_q  <= next_byte_d;
      next_valid_q <= next_valid_d;
      shift_q      <= shift_d;
      pix_fg_q     <= pix_fg_d;
      pix_in_q     <= pix_in_d;
      adb_q        <= adb;
    end
  end

  assign bus.ram_adb = adb;
  assign bus.ram_ceb = ceb;
  assign bus.pix_fg  = pix_fg_q;
  assign bus.pix_in  = pix_in_q;

endmodule

// File: tb/tb_menu_overlay_render.sv
// Bench for menu_overlay_render: RAM model on port B, a tile/bit-queue reference
// model compared every cycle, and literal expectations for the key scenarios.
module tb_menu_overlay_render;

  logic clk = 1'b0;
  logic reset;
  menu_overlay_render_if bus();

  menu_overlay_render dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:2047];
  logic [10:0] alog[$];
  int  tests  = 0;
  int  failed = 0;
  bit  chk_en = 1'b0;
  bit  exp_fg = 1'b0;
  bit  exp_in = 1'b0;

  // Reference model: the pending fetched byte and the bits still to be shown.
  bit         m_have = 1'b0;
  logic [7:0] m_byte = 8'h00;
  bit         mq[$];

  always @(posedge clk) if (bus.ram_ceb) bus.ram_doutb <= mem[bus.ram_adb];

  always @(negedge clk) if (bus.ram_ceb) alog.push_back(bus.ram_adb);

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pix_fg", int'(bus.pix_fg), int'(exp_fg));
      check("pix_in", int'(bus.pix_in), int'(exp_in));
    end
  end

  function automatic int log_at(input int idx);
    if (idx < 0 || idx >= alog.size()) return -1;
    return int'(alog[idx]);
  endfunction

  function automatic logic [7:0] glyph(input int col, input logic [7:0] yy);
    logic [7:0] code, b;
    code = mem[int'(yy[7:3]) * 32 + col];
    b    = mem[1024 + int'(code[6:0]) * 8 + int'(yy[2:0])];
    return code[7] ? ~b : b;
  endfunction

  task automatic line(input logic [7:0] yy, input bit en, output int idx);
    @(posedge clk); #1;
    bus.line_start = 1'b1;
    bus.y          = yy;
    bus.enable     = en;
    m_byte = glyph(0, yy);
    m_have = 1'b1;
    @(posedge clk); #1;
    bus.line_start = 1'b0;
    idx = alog.size();
    repeat (3) @(posedge clk);
  endtask

  task automatic pix(input int xx, input bit act, input int gap, output bit fg_o, output int idx);
    bit b, nin, nfg;
    logic [7:0] lb;
    @(posedge clk); #1;
    bus.pix_ce = 1'b1;
    bus.x      = xx[7:0];
    bus.active = act;
    nin = 1'b0;
    nfg = 1'b0;
    if (act) begin
      if (xx % 8 == 0) begin
        lb = m_have ? m_byte : 8'h00;
        m_have = 1'b0;
        mq.delete();
        for (int i = 0; i < 8; i++) mq.push_back(lb[i]);
      end
      b   = (mq.size() > 0) ? mq.pop_front() : 1'b0;
      nin = bus.enable && (bus.y < 8'd224);
      nfg = nin && b;
      if (xx % 8 == 0) begin
        m_byte = glyph(((xx / 8) + 1) % 32, bus.y);
        m_have = 1'b1;
      end
    end
    @(posedge clk); #1;
    bus.pix_ce = 1'b0;
    bus.active = 1'b0;
    exp_fg = nfg;
    exp_in = nin;
    fg_o = bus.pix_fg;
    idx  = alog.size();
    repeat (gap - 2) @(posedge clk);
  endtask

  initial begin
    int li, pi;
    bit fg;
    logic [7:0] eb;
    logic [7:0] c1;

    reset = 1'b1;
    bus.enable = 1'b0; bus.pix_ce = 1'b0; bus.line_start = 1'b0;
    bus.x = '0; bus.y = '0; bus.active = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    mem[0]      = 8'h41; mem[11'h608] = 8'h0C;
    mem[33]     = 8'hC1; mem[11'h609] = 8'h1E;
    mem[31]     = 8'h21; mem[11'h508] = 8'h18;
    mem[64]     = 8'h42; mem[11'h610] = 8'h5A;
    mem[11'h380] = 8'h41;

    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_ceb", int'(bus.ram_ceb), 0);
    check("rst_adb", int'(bus.ram_adb), 0);
    check("rst_fg",  int'(bus.pix_fg), 0);
    check("rst_in",  int'(bus.pix_in), 0);

    // 'A' at column 0, then column wrap on the same line
    line(8'd0, 1'b1, li);
    check("a_char_adb", log_at(li), 'h000);
    check("a_font_adb", log_at(li + 1), 'h608);
    eb = 8'h0C;
    for (int x = 0; x < 256; x++) begin
      pix(x, 1'b1, 4, fg, pi);
      if (x < 8) check("a_fg", int'(fg), int'(eb[x]));
      if (x == 240) begin
        check("wrap_char_adb", log_at(pi), 'h01F);
        check("wrap_font_adb", log_at(pi + 1), 'h508);
        eb = 8'h18;
      end
      if (x == 248) check("wrap_col0_adb", log_at(pi), 'h000);
      if (x >= 248) check("wrap_fg", int'(fg), int'(eb[x - 248]));
    end

    // Inverse video at row 1, column 1
    line(8'd9, 1'b1, li);
    eb = 8'hE1;
    for (int x = 0; x < 16; x++) begin
      pix(x, 1'b1, 4, fg, pi);
      if (x == 0) begin
        check("inv_char_adb", log_at(pi), 'h021);
        check("inv_font_adb", log_at(pi + 1), 'h609);
      end
      if (x >= 8) check("inv_fg", int'(fg), int'(eb[x - 8]));
    end

    // Outside the window, then menu disabled
    line(8'd224, 1'b1, li);
    for (int x = 0; x < 8; x++) begin
      pix(x, 1'b1, 4, fg, pi);
      check("win_in", int'(bus.pix_in), 0);
      check("win_fg", int'(fg), 0);
    end
    line(8'd10, 1'b0, li);
    for (int x = 0; x < 8; x++) begin
      pix(x, 1'b1, 4, fg, pi);
      check("dis_in", int'(bus.pix_in), 0);
      check("dis_fg", int'(fg), 0);
    end

    // line_start lands in the FONT cycle of the column-1 fetch
    line(8'd0, 1'b1, li);
    pix(0, 1'b1, 2, fg, pi);
    c1 = mem[1];
    line(8'd16, 1'b1, li);
    check("abort_font_adb", log_at(li - 1), 'h400 | (int'(c1[6:0]) << 3));
    check("abort_char_adb", log_at(li), 'h040);
    check("abort_new_font", log_at(li + 1), 'h610);
    eb = 8'h5A;
    for (int x = 0; x < 8; x++) begin
      pix(x, 1'b1, 4, fg, pi);
      check("abort_fg", int'(fg), int'(eb[x]));
    end

    // Reset while a fetch is in its FONT cycle
    line(8'd0, 1'b1, li);
    for (int x = 0; x < 4; x++) pix(x, 1'b1, 4, fg, pi);
    check("pre_rst_fg", int'(fg), 1);
    @(posedge clk); #1;
    bus.line_start = 1'b1;
    m_byte = glyph(0, 8'd0);
    m_have = 1'b1;
    @(posedge clk); #1;
    bus.line_start = 1'b0;
    @(posedge clk); #1;
    check("font_ceb", int'(bus.ram_ceb), 1);
    check("font_adb", int'(bus.ram_adb), 'h608);
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_ceb", int'(bus.ram_ceb), 0);
    check("midrst_adb", int'(bus.ram_adb), 0);
    check("midrst_fg",  int'(bus.pix_fg), 0);
    check("midrst_in",  int'(bus.pix_in), 0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    m_have = 1'b0;
    mq.delete();
    exp_fg = 1'b0;
    exp_in = 1'b0;
    chk_en = 1'b1;
    for (int x = 0; x < 8; x++) begin
      pix(x, 1'b1, 4, fg, pi);
      check("post_rst_blank", int'(fg), 0);
    end

    // Randomised lines against the model
    for (int l = 0; l < 8; l++) begin
      line(8'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0), li);
      for (int x = 0; x < 256; x++)
        pix(x, ($urandom_range(0, 9) != 0), $urandom_range(4, 6), fg, pi);
    end

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
